// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and default line rate.
package uart_pkg;

  localparam int DEFAULT_CLK_PER_BIT = 868;
  localparam int UART_DATA_W         = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } rx_state_t;

endpackage

// File: rtl/byte_fifo.sv
// First-word-fall-through FIFO with registered head data and valid flag.
// A push into a full FIFO is accepted only when a pop frees a slot that same cycle.
module byte_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic                       full_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       rvalid_o,
  output logic [WIDTH-1:0]           rdata_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rptr_q, rptr_d, wptr_q, wptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             rvalid_q, rvalid_d;
  logic             full_s, pop_ok_s, push_ok_s;

  always_comb begin
    full_s    = (count_q == CW'(DEPTH));
    pop_ok_s  = pop_i && (count_q != {CW{1'b0}});
    push_ok_s = push_i && (!full_s || pop_ok_s);

    rptr_d  = rptr_q;
    wptr_d  = wptr_q;
    count_d = count_q;
    rdata_d = rdata_q;

    if (pop_ok_s) begin
      rptr_d = rptr_q + AW'(1);
    end else begin
      rptr_d = rptr_q;
    end
    if (push_ok_s) begin
      wptr_d = wptr_q + AW'(1);
    end else begin
      wptr_d = wptr_q;
    end

    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // The slot being written is not in mem_q yet, so a new sole entry bypasses it.
    if (count_d == {CW{1'b0}}) begin
      rdata_d = rdata_q;
    end else if (push_ok_s && (count_d == CW'(1))) begin
      rdata_d = wdata_i;
    end else begin
      rdata_d = mem_q[rptr_d];
    end
    rvalid_d = (count_d != {CW{1'b0}});
  end

  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_q[wptr_q] <= wdata_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rptr_q   <= {AW{1'b0}};
      wptr_q   <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
      rdata_q  <= {WIDTH{1'b0}};
      rvalid_q <= 1'b0;
    end else begin
      rptr_q   <= rptr_d;
      wptr_q   <= wptr_d;
      count_q  <= count_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign full_o   = full_s;
  assign count_o  = count_q;
  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronizes rxd, recovers bytes with a bit-period counter,
// buffers them in a FWFT FIFO and flags framing errors and overruns.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_PER_BIT = DEFAULT_CLK_PER_BIT,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            rxd,
  output logic [UART_DATA_W-1:0]          rdata,
  output logic                            rvalid,
  input  logic                            rready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
  output logic                            frame_err,
  output logic                            overrun
);

  localparam int CW = $clog2(CLK_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLK_PER_BIT / 2 - 1);

  logic                   meta_q, rxs_q;
  rx_state_t              state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [2:0]             idx_q, idx_d;
  logic [UART_DATA_W-1:0] sh_q, sh_d;
  logic                   frame_err_q, overrun_q;
  logic                   push_s, fe_s, ov_s, full_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b1;
      rxs_q  <= 1'b1;
    end else begin
      meta_q <= rxd;
      rxs_q  <= meta_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    push_s  = 1'b0;
    fe_s    = 1'b0;

    case (state_q)
      IDLE: begin
        if (!rxs_q) begin
          state_d = START;
          cnt_d   = {CW{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (cnt_q == CNT_HALF) begin
          if (rxs_q) begin
            state_d = IDLE;
          end else begin
            state_d = DATA;
            cnt_d   = {CW{1'b0}};
            idx_d   = 3'd0;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DATA: begin
        if (cnt_q == CNT_LAST) begin
          sh_d  = {rxs_q, sh_q[UART_DATA_W-1:1]};
          cnt_d = {CW{1'b0}};
          if (idx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      // Sampling mid-stop and returning to IDLE at once leaves half a bit of slack.
      STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = {CW{1'b0}};
          if (rxs_q) begin
            push_s  = 1'b1;
            state_d = IDLE;
          end else begin
            fe_s    = 1'b1;
            state_d = BREAK;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      BREAK: begin
        if (rxs_q) begin
          state_d = IDLE;
        end else begin
          state_d = BREAK;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    ov_s = push_s && full_s && !(rvalid && rready);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= {CW{1'b0}};
      idx_q       <= 3'd0;
      sh_q        <= {UART_DATA_W{1'b0}};
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      sh_q        <= sh_d;
      frame_err_q <= fe_s;
      overrun_q   <= ov_s;
    end
  end

  byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (UART_DATA_W)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push_i   (push_s),
    .wdata_i  (sh_q),
    .pop_i    (rready),
    .full_o   (full_s),
    .count_o  (fifo_count),
    .rvalid_o (rvalid),
    .rdata_o  (rdata)
  );

  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit with a 4-entry FIFO.
module tb_uart_rx;

  localparam int CPB   = 16;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst, rxd, rready;
  logic [7:0] rdata;
  logic       rvalid;
  logic [2:0] fifo_count;
  logic       frame_err, overrun;

  int   n_chk = 0, n_fail = 0;
  int   cyc = 0;
  int   fe_cnt = 0, ov_cnt = 0, last_rise = 0, last_fe = 0;
  logic rvalid_prev = 1'b0;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       exp_valid;
    logic [7:0] exp_rdata;
    logic [2:0] exp_count;
    int         exp_fe;
  } vec_t;

  vec_t vecs [5];

  always #5 clk = ~clk;

  uart_rx #(.CLK_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .rxd        (rxd),
    .rdata      (rdata),
    .rvalid     (rvalid),
    .rready     (rready),
    .fifo_count (fifo_count),
    .frame_err  (frame_err),
    .overrun    (overrun)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse counters and rvalid rise time, sampled mid-cycle.
  always @(negedge clk) begin
    if (rvalid && !rvalid_prev) last_rise <= cyc;
    if (frame_err) begin
      fe_cnt  <= fe_cnt + 1;
      last_fe <= cyc;
    end
    if (overrun) ov_cnt <= ov_cnt + 1;
    rvalid_prev <= rvalid;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pop_one();
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
  endtask

  // Start bit, 8 data bits LSB first, stop bit; optional one-cycle pop at the stop sample.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int extra_low,
                            input logic pop_at_stop, output int t0);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    t0 = cyc;
    for (int j = 0; j < 10; j++) begin
      for (int k = 0; k < CPB; k++) begin
        if (k == 0) rxd = bits[j];
        if (pop_at_stop) rready = (j == 9 && k == 10);
        @(negedge clk);
      end
    end
    if (pop_at_stop) rready = 1'b0;
    if (extra_low > 0) begin
      rxd = 1'b0;
      repeat (extra_low) @(negedge clk);
    end
    rxd = 1'b1;
  endtask

  initial begin
    int t0, f0, o0;
    logic [7:0] bits5a;

    vecs[0] = '{data: 8'h3C, stop: 1'b1, exp_valid: 1'b1, exp_rdata: 8'h3C, exp_count: 3'd1, exp_fe: 0};
    vecs[1] = '{data: 8'h00, stop: 1'b1, exp_valid: 1'b1, exp_rdata: 8'h00, exp_count: 3'd1, exp_fe: 0};
    vecs[2] = '{data: 8'hFF, stop: 1'b1, exp_valid: 1'b1, exp_rdata: 8'hFF, exp_count: 3'd1, exp_fe: 0};
    vecs[3] = '{data: 8'h96, stop: 1'b0, exp_valid: 1'b0, exp_rdata: 8'h00, exp_count: 3'd0, exp_fe: 1};
    vecs[4] = '{data: 8'h81, stop: 1'b1, exp_valid: 1'b1, exp_rdata: 8'h81, exp_count: 3'd1, exp_fe: 0};

    rst = 1'b1; rxd = 1'b1; rready = 1'b0;
    idle(3);
    chk("reset rvalid", {31'd0, rvalid}, 32'd0);
    chk("reset rdata", {24'd0, rdata}, 32'd0);
    chk("reset count", {29'd0, fifo_count}, 32'd0);
    chk("reset frame_err", {31'd0, frame_err}, 32'd0);
    chk("reset overrun", {31'd0, overrun}, 32'd0);
    rst = 1'b0;
    idle(4);

    // Single byte, including exact receive latency.
    send_frame(8'hA5, 1'b1, 0, 1'b0, t0);
    idle(2);
    chk("single latency", last_rise - t0, 32'd155);
    chk("single rvalid", {31'd0, rvalid}, 32'd1);
    chk("single rdata", {24'd0, rdata}, 32'hA5);
    chk("single count", {29'd0, fifo_count}, 32'd1);
    pop_one();
    chk("single pop rvalid", {31'd0, rvalid}, 32'd0);
    chk("single pop count", {29'd0, fifo_count}, 32'd0);

    for (int i = 0; i < 5; i++) begin
      f0 = fe_cnt;
      send_frame(vecs[i].data, vecs[i].stop, 0, 1'b0, t0);
      idle(4);
      chk($sformatf("vec%0d count", i), {29'd0, fifo_count}, {29'd0, vecs[i].exp_count});
      chk($sformatf("vec%0d rvalid", i), {31'd0, rvalid}, {31'd0, vecs[i].exp_valid});
      chk($sformatf("vec%0d frame_err", i), fe_cnt - f0, vecs[i].exp_fe);
      if (vecs[i].exp_valid) begin
        chk($sformatf("vec%0d rdata", i), {24'd0, rdata}, {24'd0, vecs[i].exp_rdata});
        pop_one();
      end
    end

    // Short low pulse is rejected as a glitch.
    f0 = fe_cnt;
    rxd = 1'b0;
    idle(5);
    rxd = 1'b1;
    idle(30);
    chk("glitch count", {29'd0, fifo_count}, 32'd0);
    chk("glitch frame_err", fe_cnt - f0, 32'd0);
    send_frame(8'h3C, 1'b1, 0, 1'b0, t0);
    idle(4);
    chk("post-glitch rdata", {24'd0, rdata}, 32'h3C);
    pop_one();

    // Bad stop bit followed by a held-low line.
    f0 = fe_cnt;
    send_frame(8'h3C, 1'b0, 40, 1'b0, t0);
    idle(4);
    chk("break frame_err pulses", fe_cnt - f0, 32'd1);
    chk("break frame_err time", last_fe - t0, 32'd155);
    chk("break count", {29'd0, fifo_count}, 32'd0);
    send_frame(8'h81, 1'b1, 0, 1'b0, t0);
    idle(4);
    chk("post-break rdata", {24'd0, rdata}, 32'h81);
    pop_one();

    // Overrun: fifth byte dropped.
    o0 = ov_cnt;
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 0, 1'b0, t0);
    idle(4);
    chk("overrun count", {29'd0, fifo_count}, 32'd4);
    chk("overrun pulses", ov_cnt - o0, 32'd1);
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("overrun pop%0d", i), {24'd0, rdata}, i);
      pop_one();
    end
    chk("overrun drained", {31'd0, rvalid}, 32'd0);

    // Push into a full FIFO with a simultaneous pop.
    o0 = ov_cnt;
    for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1, 0, 1'b0, t0);
    send_frame(8'h05, 1'b1, 0, 1'b1, t0);
    idle(4);
    chk("full+pop overrun", ov_cnt - o0, 32'd0);
    chk("full+pop count", {29'd0, fifo_count}, 32'd4);
    for (int i = 2; i <= 5; i++) begin
      chk($sformatf("full+pop out%0d", i), {24'd0, rdata}, i);
      pop_one();
    end
    chk("full+pop empty count", {29'd0, fifo_count}, 32'd0);

    // Reset during data bit 3, with one byte already buffered.
    send_frame(8'hA5, 1'b1, 0, 1'b0, t0);
    idle(4);
    bits5a = 8'h5A;
    rxd = 1'b0;
    idle(CPB);
    for (int j = 0; j < 4; j++) begin
      rxd = bits5a[j];
      idle((j < 3) ? CPB : CPB / 2);
    end
    rst = 1'b1;
    rxd = 1'b1;
    #1;
    chk("midreset rvalid", {31'd0, rvalid}, 32'd0);
    chk("midreset count", {29'd0, fifo_count}, 32'd0);
    chk("midreset rdata", {24'd0, rdata}, 32'd0);
    chk("midreset frame_err", {31'd0, frame_err}, 32'd0);
    chk("midreset overrun", {31'd0, overrun}, 32'd0);
    idle(3);
    rst = 1'b0;
    idle(4);
    send_frame(8'h5A, 1'b1, 0, 1'b0, t0);
    idle(4);
    chk("post-reset rdata", {24'd0, rdata}, 32'h5A);
    chk("post-reset count", {29'd0, fifo_count}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receive front end for the I/O core controller. Samples the board UART input line (idle-high, 8N1, LSB first) and recovers bytes with a bit-period counter. Buffers received bytes in a small first-word-fall-through FIFO and presents them to the controller over a valid/ready handshake. Reports framing errors and overruns as single-cycle pulses.

## Interface
- `CLK_PER_BIT`, default 868: clock cycles per bit (100 MHz / 115200 baud). Must be ≥ 8.
- `FIFO_DEPTH`, default 16: byte FIFO depth. Power of two, ≥ 2.
- `clk`  in  1  system clock (100 MHz). This is the only clock.
- `rst`  in  1  asynchronous reset, active-high.
- `rxd`  in  1  raw serial input, asynchronous to `clk`, idle high.
- `rdata`  out  8  FIFO head byte. Meaningful only while `rvalid` is high.
- `rvalid`  out  1  FIFO is not empty.
- `rready`  in  1  consumer accepts `rdata`. A pop happens on a cycle where `rvalid && rready`.
- `fifo_count`  out  $clog2(FIFO_DEPTH+1)  current occupancy.
- `frame_err`  out  1  one-cycle pulse: stop bit sampled as 0.
- `overrun`  out  1  one-cycle pulse: a good byte was dropped because the FIFO was full.

## Operation
- **Input synchronizer:** `rxd` passes through a 2-FF synchronizer whose flops reset to 1. All logic below uses the synchronized value `rxs`.
- **Bit counter:** `cnt` is $clog2(CLK_PER_BIT) bits wide. **Bit index:** `idx` is 3 bits. **Shift register:** `sh` is 8 bits and shifts right, so the first data bit ends up as `sh[0]`.
- **State machine:**
  - IDLE: when `rxs==0`, go to START with `cnt=0`.
  - START: when `cnt==CLK_PER_BIT/2-1`, sample the line (mid start bit).
    - If `rxs==1`, treat it as a glitch: go to IDLE, push nothing.
    - Otherwise set `cnt=0`, `idx=0`, and go to DATA.
  - DATA: when `cnt==CLK_PER_BIT-1`, shift `rxs` into `sh` and set `cnt=0`. After `idx==7` is sampled, go to STOP; otherwise increment `idx`.
  - STOP: when `cnt==CLK_PER_BIT-1`, sample the stop bit.
    - If `rxs==1`, request a push of `sh` and go straight to IDLE. This gives half-bit early resync.
    - If `rxs==0`, pulse `frame_err`, discard the byte, and go to BREAK.
  - BREAK: stay until `rxs==1`, then go to IDLE. A held-low line (break) therefore produces exactly one `frame_err`.
- **FIFO push rule:** a push is accepted if the FIFO is not full, or if a pop occurs in the same cycle. Otherwise the byte is dropped and `overrun` pulses that cycle.
- **Simultaneous push and pop:** `fifo_count` is unchanged and the head advances.
- **Pointer wrap:** read and write pointers are $clog2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH.
- **Empty FIFO:** `rdata` holds the last read value and is don't-care. A pop with `rvalid` low has no effect.

## Timing
- **Reset values (asynchronous, immediate):**
  - State IDLE; `cnt`, `idx`, `sh` = 0; synchronizer = 1.
  - Pointers 0, `fifo_count`=0, `rvalid`=0, `rdata`=0.
  - `frame_err`=0, `overrun`=0.
- **Reset mid-frame:** the partial byte is lost and the FIFO is emptied. After release the receiver rearms in IDLE; a line held low at that point is treated as a new start bit.
- **Pin to synchronized line:** 2 cycles.
- **Receive latency:** `rvalid` (or the `fifo_count` increment) appears the cycle after the stop-bit sample cycle.
- **Stop-bit sample point:** 2 + CLK_PER_BIT/2 + 9·CLK_PER_BIT cycles after the first low cycle on `rxd`.
- **Read timing:** `rdata`/`rvalid` are registered FIFO outputs. After a pop, the next byte is visible in the following cycle. One pop per cycle is sustained.
- **Error pulses:** `frame_err` and `overrun` are registered, high for exactly 1 cycle, and aligned with the push-attempt cycle.

## Structure
- **Shared package `uart_pkg`:**
  - `rx_state_t` enum {IDLE, START, DATA, STOP, BREAK}.
  - `DEFAULT_CLK_PER_BIT` = 868.
  - `UART_DATA_W` = 8.
  - The TX side will reuse this package.
- **Sub-module `byte_fifo`:** the synchronous FWFT FIFO, parameterized by depth and width. It exposes push/pop/full/count. `uart_rx` instantiates it once.

## Test plan
All scenarios use CLK_PER_BIT=16 and FIFO_DEPTH=4.
- **Single byte:** send 0xA5 with `rready`=0 → `rvalid`=1, `rdata`=0xA5, `fifo_count`=1. Raise `rready` for 1 cycle → `rvalid`=0, `fifo_count`=0.
- **Glitch:** drive `rxd` low for 5 cycles, then high → no push and no `frame_err`. A following 0x3C is then received correctly.
- **Framing error:** send 0x3C with the stop bit 0 and hold the line low for 40 cycles → exactly one `frame_err` pulse and `fifo_count` stays 0. Then sending 0x81 → `rdata`=0x81.
- **Overrun:** hold `rready`=0 and send 0x01–0x05 back-to-back → `fifo_count`=4, one `overrun` pulse on the 5th byte, and popping yields 0x01, 0x02, 0x03, 0x04.
- **Push at full with pop:** hold `rready`=1 on the stop-sample cycle of the 5th byte → no `overrun`, `fifo_count` stays 4, and 0x05 is last out.
- **Reset mid-frame:** assert `rst` during DATA bit 3 → all outputs at reset values immediately. A clean 0x5A after release → `rdata`=0x5A.
